// File: rtl/ipq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ipq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ipq_entry_t;

    localparam int          INST_BYTES    = 4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Sequential fetch address; wraps from 32'hFFFF_FFFC to 0 by natural overflow.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'(INST_BYTES);
    endfunction

endpackage

// File: rtl/ipq_fifo.sv
// In-order entry buffer for fetched words: wrap-around pointers, occupancy count,
// and a flush that empties it in one cycle (flush wins over push and pop).
module ipq_fifo
    import ipq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  ipq_entry_t             push_data,
    input  logic                   pop,
    input  logic                   flush,
    output ipq_entry_t             head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    ipq_entry_t        mem_reg [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              full;
    logic              push_en;
    logic              pop_en;
    logic [DEPTH-1:0]  wr_en;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_en && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The issue credit in the parent must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (srst) !(push && full && !flush));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues imem word reads under a credit
// limit, buffers responses in order, and flushes on redirect. IPQ_BYPASS_EN adds a
// zero-latency path from imem response to the core when the buffer is empty.
module inst_prefetch_queue
    import ipq_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          MAX_INFLIGHT = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_b,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            fetch_inst,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   halted,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [31:0]   next_pc_reg;
    logic [31:0]   rsp_pc_reg;
    logic [CW-1:0] live_reg;
    logic [CW-1:0] drop_reg;

    logic          credit_ok;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          bypass;
    logic          q_push;
    logic          q_pop;
    logic          q_empty;
    ipq_entry_t    q_head;
    ipq_entry_t    rsp_entry;
    logic [31:0]   redirect_aligned;

    // Buffer space must cover every live request, and imem never holds more than
    // MAX_INFLIGHT accepted requests including ones whose answers will be discarded.
    assign credit_ok = (32'(q_count) + 32'(live_reg) < 32'(DEPTH)) &&
                       (32'(live_reg) + 32'(drop_reg) < 32'(MAX_INFLIGHT));

    assign imem_req_valid   = !rst_b && !halted && !redirect_valid && credit_ok;
    assign imem_req_addr    = next_pc_reg;
    assign req_fire         = imem_req_valid && imem_req_ready;

    assign rsp_drop         = imem_rsp_valid && (drop_reg != '0);
    assign rsp_keep         = imem_rsp_valid && (drop_reg == '0);
    assign rsp_entry        = '{pc: rsp_pc_reg, inst: imem_rsp_data};
    assign redirect_aligned = redirect_pc & PC_ALIGN_MASK;

`ifdef IPQ_BYPASS_EN
    assign bypass      = rsp_keep && q_empty && !redirect_valid && fetch_ready;
    assign fetch_valid = !q_empty || bypass;
    assign fetch_pc    = q_empty ? rsp_pc_reg : q_head.pc;
    assign fetch_inst  = q_empty ? imem_rsp_data : q_head.inst;
`else
    assign bypass      = 1'b0;
    assign fetch_valid = !q_empty;
    assign fetch_pc    = q_head.pc;
    assign fetch_inst  = q_head.inst;
`endif

    assign q_push = rsp_keep && !redirect_valid && !bypass;
    assign q_pop  = fetch_ready && !q_empty && !redirect_valid;

    ipq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst_b),
        .push      (q_push),
        .push_data (rsp_entry),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            next_pc_reg <= RESET_PC;
            rsp_pc_reg  <= RESET_PC;
            live_reg    <= '0;
            drop_reg    <= '0;
        end else if (redirect_valid) begin
            // Every request still owed by imem becomes a response to throw away.
            next_pc_reg <= redirect_aligned;
            rsp_pc_reg  <= redirect_aligned;
            drop_reg    <= drop_reg + live_reg - CW'(rsp_keep) - CW'(rsp_drop);
            live_reg    <= '0;
        end else begin
            if (req_fire) begin
                next_pc_reg <= pc_next(next_pc_reg);
            end
            if (rsp_keep) begin
                rsp_pc_reg <= pc_next(rsp_pc_reg);
            end
            live_reg <= live_reg + CW'(req_fire) - CW'(rsp_keep);
            drop_reg <= drop_reg - CW'(rsp_drop);
        end
    end

    assert property (@(posedge clk) disable iff (rst_b)
        32'(live_reg) + 32'(drop_reg) <= 32'(MAX_INFLIGHT));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue: an imem model with variable latency and an
// epoch-tagged reference queue predict every request, occupancy and delivered fetch.
module tb_inst_prefetch_queue;

    localparam int          DEPTH        = 4;
    localparam int          MAX_INFLIGHT = 2;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          NUM_CYCLES   = 2400;

    logic                   clk = 1'b0;
    logic                   rst_b;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [31:0]            imem_req_addr;
    logic                   imem_rsp_valid;
    logic [31:0]            imem_rsp_data;
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [31:0]            fetch_pc;
    logic [31:0]            fetch_inst;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   halted;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clk = ~clk;

    inst_prefetch_queue #(
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .q_count        (q_count)
    );

    // Accepted imem request: address, redirect epoch it belongs to, earliest answer cycle.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    int          epoch;
    int          cycle;
    int          n_checks;
    int          n_errors;
    int          n_fetched;
    logic [31:0] m_next_pc;
    logic [31:0] tgt_tab [5];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mq.delete();
        m_next_pc = RESET_PC;
        epoch     = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halted         = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            #1;
            check_val("rst_req_valid", 32'(imem_req_valid), 32'h0);
            check_val("rst_fetch_valid", 32'(fetch_valid), 32'h0);
            check_val("rst_q_count", 32'(q_count), 32'h0);
        end
        rst_b = 1'b0;
    endtask

    initial begin
        int          fr_mode;
        int          halt_mode;
        int          cur_out;
        logic        exp_rv;
        logic        exp_fv;
        logic        byp;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        req_t        h;

        n_checks  = 0;
        n_errors  = 0;
        n_fetched = 0;
        cycle     = 0;
        fr_mode   = 0;
        halt_mode = 0;
        tgt_tab[0] = 32'h0000_0203;
        tgt_tab[1] = 32'hFFFF_FFFC;
        tgt_tab[2] = 32'hFFFF_FFF6;
        tgt_tab[3] = 32'h0000_1000;
        tgt_tab[4] = 32'h0000_0010;

        do_reset();

        for (int c = 0; c < NUM_CYCLES; c++) begin
            if (c == NUM_CYCLES / 2) begin
                do_reset();
            end

            @(negedge clk);
            // Stimulus phases: free-running start, then random mixes of stalls and halts.
            if (c >= 40 && (c % 64) == 0) begin
                fr_mode   = int'($urandom_range(0, 2));
                halt_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end
            fetch_ready    = (fr_mode == 0) ? 1'b1 :
                             (fr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            halted         = (halt_mode != 0);
            imem_req_ready = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            redirect_valid = (c >= 40) && ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? tgt_tab[$urandom_range(0, 4)]
                                                         : $urandom;
            imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cycle) &&
                             ((c < 40) || ($urandom_range(0, 4) != 0));
            imem_rsp_data  = imem_rsp_valid ? word_of(pend[0].addr) : $urandom;
            #1;

            cur_out = 0;
            foreach (pend[i]) begin
                if (pend[i].epoch == epoch) cur_out++;
            end
            exp_rv = !halted && !redirect_valid && (mq.size() + cur_out < DEPTH) &&
                     (pend.size() < MAX_INFLIGHT);
            byp = 1'b0;
`ifdef IPQ_BYPASS_EN
            byp = imem_rsp_valid && (pend[0].epoch == epoch) && (mq.size() == 0) &&
                  !redirect_valid && fetch_ready;
`endif
            exp_fv = (mq.size() != 0) || byp;

            check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) check_val("req_addr", imem_req_addr, m_next_pc);
            check_val("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
            check_val("q_count", 32'(q_count), 32'(mq.size()));
            if (exp_fv) begin
                exp_pc   = (mq.size() != 0) ? mq[0].pc : pend[0].addr;
                exp_inst = (mq.size() != 0) ? mq[0].inst : word_of(pend[0].addr);
                check_val("fetch_pc", fetch_pc, exp_pc);
                check_val("fetch_inst", fetch_inst, exp_inst);
                if (fetch_ready && !redirect_valid) begin
                    n_fetched++;
                    $display("fetch #%0d cycle %0d pc=%h inst=%h", n_fetched, cycle,
                             exp_pc, exp_inst);
                    if (!byp) void'(mq.pop_front());
                end
            end

            if (imem_rsp_valid) begin
                h = pend.pop_front();
                if (!redirect_valid && !byp && h.epoch == epoch) begin
                    mq.push_back('{pc: h.addr, inst: word_of(h.addr)});
                end
            end
            if (redirect_valid) begin
                mq.delete();
                m_next_pc = redirect_pc & 32'hFFFF_FFFC;
                epoch++;
            end
            if (exp_rv && imem_req_ready) begin
                pend.push_back('{addr: m_next_pc, epoch: epoch, due: cycle + 1});
                m_next_pc = m_next_pc + 32'd4;
            end
            cycle++;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
